// File: rtl/mips_fetch_unit_if.sv
// mips_fetch_unit_if: bundles the fetch unit's imem and decode-side signals.
//   master : the fetch unit (drives instr_addr, out_*, halted)
//   slave  : the surrounding core (imem data, decode stall, redirect)
interface mips_fetch_unit_if;
    logic [31:0] instr_addr;
    logic [31:0] instr_in;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        halted;

    modport master (
        output instr_addr, out_valid, out_instr, out_pc, halted,
        input  instr_in, stall, redirect_valid, redirect_pc
    );

    modport slave (
        input  instr_addr, out_valid, out_instr, out_pc, halted,
        output instr_in, stall, redirect_valid, redirect_pc
    );
endinterface

// File: rtl/mips_fetch_unit.sv
// mips_fetch_unit: instruction-fetch front end.
//   Issues instr_addr to imem, captures the word one cycle later into a
//   2-entry {pc, instr} queue and presents the queue head to decode.
//   Supports redirect with flush, and halts when the fetch pc reaches
//   halt_addr.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low
//   bus   - mips_fetch_unit_if.master (imem address/data, decode handshake,
//           redirect, halted)
module mips_fetch_unit #(
    parameter logic [31:0] pc_init   = 32'h80020000,
    parameter logic [31:0] halt_addr = 32'h00000000
) (
    input  logic                   clk,
    input  logic                   reset,
    mips_fetch_unit_if.master      bus
);

    logic [31:0] pc;
    logic        inflight;
    logic [31:0] inflight_pc;
    logic        halted;
    logic [31:0] q_pc    [2];
    logic [31:0] q_instr [2];
    logic [1:0]  count;

    logic        out_valid;
    logic        pop;
    logic        issue;
    logic [1:0]  occ;
    logic        wr_idx;

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid & ~bus.stall;

    // Slots committed after this edge if nothing new is issued. At most 2
    // because every in-flight word already owns a reserved slot.
    assign occ   = count + {1'b0, inflight} - {1'b0, pop};
    assign issue = ~halted & ~bus.redirect_valid & (pc != halt_addr) & (occ < 2'd2);

    // Slot for the captured word once the head has (maybe) shifted out.
    assign wr_idx = (count == 2'd2) || ((count == 2'd1) && !pop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc          <= pc_init;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            halted      <= 1'b0;
            count       <= '0;
            for (int i = 0; i < 2; i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= '0;
            end
        end else if (bus.redirect_valid) begin
            // Flush wins over pop and capture; the returning word is dropped.
            count    <= '0;
            inflight <= 1'b0;
            pc       <= bus.redirect_pc & ~32'h3;
            halted   <= 1'b0;
        end else begin
            if (pop) begin
                q_pc[0]    <= q_pc[1];
                q_instr[0] <= q_instr[1];
            end
            // Written after the shift so a same-edge push into slot 0 wins.
            if (inflight) begin
                q_pc[wr_idx]    <= inflight_pc;
                q_instr[wr_idx] <= bus.instr_in;
            end
            count <= count - {1'b0, pop} + {1'b0, inflight};

            if (issue) begin
                inflight    <= 1'b1;
                inflight_pc <= pc;
                pc          <= pc + 32'd4;
            end else begin
                inflight <= 1'b0;
            end

            if (!halted && pc == halt_addr)
                halted <= 1'b1;
        end
    end

    assign bus.instr_addr = pc;
    assign bus.out_valid  = out_valid;
    assign bus.out_instr  = out_valid ? q_instr[0] : '0;
    assign bus.out_pc     = out_valid ? q_pc[0]    : '0;
    assign bus.halted     = halted;

endmodule
